// File: rtl/lenet_run_ctrl_if.sv
// Control/status bundle between the LeNet run sequencer and its host/core side.
// The master drives launch requests and core strobes; the slave is the sequencer.
interface lenet_run_ctrl_if #(
    parameter int RUN_W = 16,
    parameter int LAT_W = 32
);
    logic             go;
    logic [RUN_W-1:0] num_runs;
    logic             core_done;
    logic             startt_valid;
    logic             stopt_valid;
    logic             ap_start;
    logic             busy;
    logic [RUN_W-1:0] run_idx;
    logic             lat_valid;
    logic [LAT_W-1:0] lat_cycles;
    logic             done_all;
    logic             err_timeout;

    modport master (
        output go, num_runs, core_done, startt_valid, stopt_valid,
        input  ap_start, busy, run_idx, lat_valid, lat_cycles, done_all, err_timeout
    );

    modport slave (
        input  go, num_runs, core_done, startt_valid, stopt_valid,
        output ap_start, busy, run_idx, lat_valid, lat_cycles, done_all, err_timeout
    );
endinterface

// File: rtl/lenet_run_ctrl.sv
// Sequences N back-to-back ap_ctrl_hs inferences with a watchdog and measures startt->stopt latency.
// All outputs registered (1-cycle latency); go is ignored while busy, no other backpressure.
module lenet_run_ctrl #(
    parameter int          RUN_W   = 16,
    parameter int          LAT_W   = 32,
    parameter logic [23:0] TIMEOUT = 24'hFF_FFFF
) (
    input  logic            clk,
    input  logic            ap_rst,
    lenet_run_ctrl_if.slave io_ctrl
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

    state_t           r_state, w_state_nxt;
    logic [RUN_W-1:0] r_count, w_count_nxt;
    logic [RUN_W-1:0] r_run_idx, w_run_idx_nxt;
    logic [23:0]      r_wdog, w_wdog_nxt;
    logic             r_ap_start, w_ap_start_nxt;
    logic             r_busy;
    logic             r_done_all, w_done_all_nxt;
    logic             r_err, w_err_nxt;
    logic             w_last;

    logic             r_armed;
    logic [LAT_W-1:0] r_lat_cnt, r_lat_cycles, w_lat_inc;
    logic             r_lat_valid;

    assign w_last = (r_run_idx + RUN_W'(1)) == r_count;

    always_ff @(posedge clk) begin
        if (ap_rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_run_idx  <= '0;
            r_wdog     <= '0;
            r_ap_start <= 1'b0;
            r_busy     <= 1'b0;
            r_done_all <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_run_idx  <= w_run_idx_nxt;
            r_wdog     <= w_wdog_nxt;
            r_ap_start <= w_ap_start_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done_all <= w_done_all_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // ap_start is the registered action of the current state, so GAP and START
    // both show low after a run ends: two visible low cycles between runs.
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_run_idx_nxt  = r_run_idx;
        w_wdog_nxt     = r_wdog;
        w_ap_start_nxt = 1'b0;
        w_done_all_nxt = 1'b0;
        w_err_nxt      = r_err;
        unique case (r_state)
            S_IDLE: begin
                if (io_ctrl.go) begin
                    if (io_ctrl.num_runs != '0) begin
                        w_count_nxt    = io_ctrl.num_runs;
                        w_run_idx_nxt  = '0;
                        w_err_nxt      = 1'b0;
                        w_ap_start_nxt = 1'b1;
                        w_state_nxt    = S_START;
                    end else begin
                        w_done_all_nxt = 1'b1;
                    end
                end
            end
            S_START: begin
                w_ap_start_nxt = 1'b1;
                w_wdog_nxt     = '0;
                w_state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                if (io_ctrl.core_done) begin
                    if (w_last) begin
                        w_done_all_nxt = 1'b1;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        w_run_idx_nxt = r_run_idx + RUN_W'(1);
                        w_state_nxt   = S_GAP;
                    end
                end else if (r_wdog == TIMEOUT - 24'd1) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wdog_nxt     = r_wdog + 24'd1;
                    w_ap_start_nxt = 1'b1;
                end
            end
            S_GAP: begin
                w_state_nxt = S_START;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_lat_inc = (&r_lat_cnt) ? r_lat_cnt : r_lat_cnt + LAT_W'(1);

    // The latched value includes the stopt edge itself, hence the +1 on capture.
    always_ff @(posedge clk) begin
        if (ap_rst) begin
            r_armed      <= 1'b0;
            r_lat_cnt    <= '0;
            r_lat_cycles <= '0;
            r_lat_valid  <= 1'b0;
        end else begin
            r_lat_valid <= 1'b0;
            if (io_ctrl.startt_valid && io_ctrl.stopt_valid) begin
                r_lat_cnt    <= '0;
                r_lat_cycles <= '0;
                r_lat_valid  <= 1'b1;
                r_armed      <= 1'b0;
            end else if (io_ctrl.startt_valid) begin
                r_lat_cnt <= '0;
                r_armed   <= 1'b1;
            end else if (r_armed) begin
                if (io_ctrl.stopt_valid) begin
                    r_lat_cycles <= w_lat_inc;
                    r_lat_valid  <= 1'b1;
                    r_armed      <= 1'b0;
                end else begin
                    r_lat_cnt <= w_lat_inc;
                end
            end
        end
    end

    assign io_ctrl.ap_start    = r_ap_start;
    assign io_ctrl.busy        = r_busy;
    assign io_ctrl.run_idx     = r_run_idx;
    assign io_ctrl.done_all    = r_done_all;
    assign io_ctrl.err_timeout = r_err;
    assign io_ctrl.lat_valid   = r_lat_valid;
    assign io_ctrl.lat_cycles  = r_lat_cycles;
endmodule

// File: tb/tb_lenet_run_ctrl.sv
// Bench for lenet_run_ctrl: cycle-timeline reference model plus directed literal checks and random traffic.
`timescale 1ns/1ps
module tb_lenet_run_ctrl;
    localparam int          RUN_W   = 16;
    localparam int          LAT_W   = 32;
    localparam logic [23:0] TMO     = 24'd50;
    localparam longint      LAT_MAX = (longint'(1) << LAT_W) - 1;

    logic clk = 1'b0;
    logic ap_rst;
    lenet_run_ctrl_if #(.RUN_W(RUN_W), .LAT_W(LAT_W)) bus ();

    lenet_run_ctrl #(.RUN_W(RUN_W), .LAT_W(LAT_W), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .ap_rst  (ap_rst),
        .io_ctrl (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a timeline of when ap_start rises and when core_done is honoured.
    longint           cyc = 0;
    bit               m_busy = 0;
    int               m_count = 0;
    longint           m_rise = 0, m_win = 0, m_t0 = 0;
    bit               m_armed = 0;
    logic             e_ap_start = 0, e_busy = 0, e_done_all = 0, e_err = 0, e_lat_valid = 0;
    logic [RUN_W-1:0] e_run_idx = '0;
    logic [LAT_W-1:0] e_lat = '0;

    int   rises = 0, gaps_ok = 0, gaps_bad = 0, done_cnt = 0, low_len = 0;
    logic prev_as = 1'b0;
    int   idx_q[$];

    always @(posedge clk) begin
        if (ap_rst) begin
            m_busy = 0; m_armed = 0;
            e_ap_start = 0; e_busy = 0; e_run_idx = '0; e_done_all = 0;
            e_err = 0; e_lat_valid = 0; e_lat = '0;
        end else begin
            e_done_all = 0;
            if (!m_busy) begin
                if (bus.go) begin
                    if (bus.num_runs == '0) e_done_all = 1;
                    else begin
                        m_busy = 1; m_count = int'(bus.num_runs); e_run_idx = '0; e_err = 0;
                        m_rise = cyc + 1; m_win = cyc + 2;
                    end
                end
            end else if (cyc >= m_win) begin
                if (bus.core_done) begin
                    if (int'(e_run_idx) + 1 == m_count) begin
                        m_busy = 0; e_done_all = 1;
                    end else begin
                        e_run_idx = e_run_idx + 1'b1; m_rise = cyc + 3; m_win = cyc + 3;
                    end
                end else if (cyc - m_win + 1 == longint'(TMO)) begin
                    m_busy = 0; e_err = 1;
                end
            end
            e_busy     = m_busy;
            e_ap_start = m_busy && (cyc + 1 >= m_rise);

            e_lat_valid = 0;
            if (bus.startt_valid && bus.stopt_valid) begin
                e_lat_valid = 1; e_lat = '0; m_armed = 0;
            end else if (bus.startt_valid) begin
                m_armed = 1; m_t0 = cyc;
            end else if (bus.stopt_valid && m_armed) begin
                e_lat_valid = 1; m_armed = 0;
                e_lat = LAT_W'((cyc - m_t0 > LAT_MAX) ? LAT_MAX : cyc - m_t0);
            end
        end
        cyc++;
        #1;
        cmp("ap_start", bus.ap_start, e_ap_start);
        cmp("busy", bus.busy, e_busy);
        cmp("run_idx", bus.run_idx, e_run_idx);
        cmp("done_all", bus.done_all, e_done_all);
        cmp("err_timeout", bus.err_timeout, e_err);
        cmp("lat_valid", bus.lat_valid, e_lat_valid);
        if (e_lat_valid) cmp("lat_cycles", bus.lat_cycles, e_lat);

        if (bus.done_all === 1'b1) done_cnt++;
        if (bus.ap_start === 1'b1 && prev_as !== 1'b1) begin
            rises++;
            idx_q.push_back(int'(bus.run_idx));
            if (low_len != 0) begin
                if (low_len == 2) gaps_ok++;
                else gaps_bad++;
            end
            low_len = 0;
        end else if (bus.busy === 1'b1 && bus.ap_start !== 1'b1) low_len++;
        else if (bus.busy !== 1'b1) low_len = 0;
        prev_as = bus.ap_start;
    end

    // Core model: core_done a fixed or random number of cycles after each ap_start rise.
    int core_mode = 1;
    int core_delay = 10;
    int cd_cnt = 0;
    bit as_q = 0;

    always @(negedge clk) begin
        bus.core_done = 1'b0;
        if (bus.ap_start === 1'b1 && !as_q) begin
            case (core_mode)
                1: cd_cnt = core_delay;
                2: cd_cnt = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
                default: cd_cnt = 0;
            endcase
        end else if (cd_cnt > 0) begin
            cd_cnt--;
            if (cd_cnt == 0) bus.core_done = 1'b1;
        end
        if (core_mode == 2 && bus.ap_start !== 1'b1 && $urandom_range(0, 24) == 0) bus.core_done = 1'b1;
        as_q = (bus.ap_start === 1'b1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (bus.busy !== 1'b0 && n < lim) begin
            tick();
            n++;
        end
        cmp("wait_idle", bus.busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench stalled");
    end

    int b_r, b_d, b_g, b_gb, b_q;

    initial begin
        ap_rst = 1'b1;
        bus.go = 1'b0; bus.num_runs = '0; bus.startt_valid = 1'b0; bus.stopt_valid = 1'b0;
        repeat (3) tick();
        cmp("rst_ap_start", bus.ap_start, 0);
        cmp("rst_busy", bus.busy, 0);
        cmp("rst_run_idx", bus.run_idx, 0);
        cmp("rst_done_all", bus.done_all, 0);
        cmp("rst_err", bus.err_timeout, 0);
        cmp("rst_lat_valid", bus.lat_valid, 0);
        cmp("rst_lat_cycles", bus.lat_cycles, 0);
        ap_rst = 1'b0;
        tick();

        // three runs, core_done 10 cycles after each rise
        b_r = rises; b_d = done_cnt; b_g = gaps_ok; b_gb = gaps_bad; b_q = idx_q.size();
        bus.go = 1'b1; bus.num_runs = 16'd3; tick(); bus.go = 1'b0;
        cmp("go_busy", bus.busy, 1);
        cmp("go_ap_start", bus.ap_start, 1);
        wait_idle(200);
        cmp("runs3_rises", rises - b_r, 3);
        cmp("runs3_gaps_of_2", gaps_ok - b_g, 2);
        cmp("runs3_bad_gaps", gaps_bad - b_gb, 0);
        cmp("runs3_done_pulses", done_cnt - b_d, 1);
        if (idx_q.size() >= b_q + 3) begin
            cmp("runs3_idx0", idx_q[b_q], 0);
            cmp("runs3_idx1", idx_q[b_q + 1], 1);
            cmp("runs3_idx2", idx_q[b_q + 2], 2);
        end
        tick();

        // zero runs
        bus.go = 1'b1; bus.num_runs = '0; tick(); bus.go = 1'b0;
        cmp("zero_done_all", bus.done_all, 1);
        cmp("zero_busy", bus.busy, 0);
        cmp("zero_ap_start", bus.ap_start, 0);
        tick();
        cmp("zero_done_once", bus.done_all, 0);

        // latency 37, stray stop, simultaneous start/stop
        bus.startt_valid = 1'b1; tick(); bus.startt_valid = 1'b0;
        repeat (36) tick();
        bus.stopt_valid = 1'b1; tick(); bus.stopt_valid = 1'b0;
        cmp("lat37_valid", bus.lat_valid, 1);
        cmp("lat37_cycles", bus.lat_cycles, 37);
        repeat (12) tick();
        bus.stopt_valid = 1'b1; tick(); bus.stopt_valid = 1'b0;
        cmp("stray_stop_valid", bus.lat_valid, 0);
        cmp("stray_stop_hold", bus.lat_cycles, 37);
        bus.startt_valid = 1'b1; bus.stopt_valid = 1'b1; tick();
        bus.startt_valid = 1'b0; bus.stopt_valid = 1'b0;
        cmp("simul_valid", bus.lat_valid, 1);
        cmp("simul_cycles", bus.lat_cycles, 0);

        // watchdog with a silent core
        core_mode = 0; b_d = done_cnt;
        bus.go = 1'b1; bus.num_runs = 16'd1; tick(); bus.go = 1'b0;
        repeat (50) tick();
        cmp("wd_before_ap_start", bus.ap_start, 1);
        cmp("wd_before_err", bus.err_timeout, 0);
        tick();
        cmp("wd_err", bus.err_timeout, 1);
        cmp("wd_ap_start", bus.ap_start, 0);
        cmp("wd_busy", bus.busy, 0);
        cmp("wd_no_done", done_cnt - b_d, 0);
        core_mode = 1;
        bus.go = 1'b1; bus.num_runs = 16'd1; tick(); bus.go = 1'b0;
        cmp("wd_err_cleared", bus.err_timeout, 0);
        wait_idle(200);

        // go while busy is ignored
        b_r = rises; b_d = done_cnt;
        bus.go = 1'b1; bus.num_runs = 16'd2; tick(); bus.go = 1'b0;
        repeat (5) tick();
        bus.go = 1'b1; bus.num_runs = 16'd9; tick(); bus.go = 1'b0;
        wait_idle(300);
        cmp("busy_go_rises", rises - b_r, 2);
        cmp("busy_go_done", done_cnt - b_d, 1);

        // reset during WAIT with a latency measurement armed
        b_d = done_cnt;
        bus.go = 1'b1; bus.num_runs = 16'd3; bus.startt_valid = 1'b1; tick();
        bus.go = 1'b0; bus.startt_valid = 1'b0;
        repeat (2) tick();
        bus.stopt_valid = 1'b1; tick(); bus.stopt_valid = 1'b0;
        cmp("mid_lat_cycles", bus.lat_cycles, 3);
        bus.startt_valid = 1'b1; tick(); bus.startt_valid = 1'b0;
        ap_rst = 1'b1; tick(); ap_rst = 1'b0;
        cmp("mrst_ap_start", bus.ap_start, 0);
        cmp("mrst_busy", bus.busy, 0);
        cmp("mrst_run_idx", bus.run_idx, 0);
        cmp("mrst_done_all", bus.done_all, 0);
        cmp("mrst_lat_valid", bus.lat_valid, 0);
        cmp("mrst_lat_cycles", bus.lat_cycles, 0);
        cmp("mrst_no_done", done_cnt - b_d, 0);
        bus.stopt_valid = 1'b1; tick(); bus.stopt_valid = 1'b0;
        cmp("mrst_disarmed", bus.lat_valid, 0);

        // random traffic against the model
        core_mode = 2;
        repeat (4000) begin
            bus.go           = ($urandom_range(0, 14) == 0);
            bus.num_runs     = RUN_W'($urandom_range(0, 4));
            bus.startt_valid = ($urandom_range(0, 14) == 0);
            bus.stopt_valid  = ($urandom_range(0, 11) == 0);
            ap_rst           = ($urandom_range(0, 299) == 0);
            tick();
        end
        bus.go = 1'b0; bus.startt_valid = 1'b0; bus.stopt_valid = 1'b0; ap_rst = 1'b0;
        repeat (100) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
